// File: rtl/dna_pkg.sv
// Shared constants for the DNA sequence loader: base codes, control characters,
// default frame sizes and the loader state encoding.
package dna_pkg;

  localparam int DEF_KEY_BASES   = 32;
  localparam int DEF_DATA_BASES  = 256;
  localparam int DEF_SCAN_CYCLES = 116;

  localparam logic [1:0] BASE_A = 2'b00;
  localparam logic [1:0] BASE_C = 2'b01;
  localparam logic [1:0] BASE_G = 2'b10;
  localparam logic [1:0] BASE_T = 2'b11;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  typedef enum logic [2:0] {
    ST_LOAD_KEY,
    ST_LOAD_DATA,
    ST_START,
    ST_SCAN,
    ST_REPORT
  } state_t;

endpackage

// File: rtl/sequence_loader_if.sv
// Byte-stream input and result handshake between the loader and its host.
interface sequence_loader_if;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       result_valid;
  logic       result_found;
  logic       result_ready;

  modport master (
    output in_valid, in_byte, result_ready,
    input  in_ready, result_valid, result_found
  );

  modport slave (
    input  in_valid, in_byte, result_ready,
    output in_ready, result_valid, result_found
  );
endinterface

// File: rtl/base_encoder.sv
// Combinational ASCII-to-2-bit base decoder; CR/LF are flagged as skippable.
module base_encoder
  import dna_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [1:0] code,
  output logic       is_base,
  output logic       is_skip
);

  always_comb begin
    code    = BASE_A;
    is_base = 1'b0;
    is_skip = 1'b0;
    case (in_byte)
      8'h41, 8'h61: begin code = BASE_A; is_base = 1'b1; end
      8'h43, 8'h63: begin code = BASE_C; is_base = 1'b1; end
      8'h47, 8'h67: begin code = BASE_G; is_base = 1'b1; end
      8'h54, 8'h74: begin code = BASE_T; is_base = 1'b1; end
      CHAR_LF, CHAR_CR: is_skip = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/sequence_loader.sv
// Packs an ASCII base stream into a key and data window, strobes the searcher,
// collects its match flag over a fixed scan window and reports the result.
module sequence_loader
  import dna_pkg::*;
#(
  parameter int KEY_BASES   = DEF_KEY_BASES,
  parameter int DATA_BASES  = DEF_DATA_BASES,
  parameter int SCAN_CYCLES = DEF_SCAN_CYCLES
) (
  input  logic                    clock,
  input  logic                    reset,
  sequence_loader_if.slave        bus,
  output logic [2*DATA_BASES-1:0] data,
  output logic [2*KEY_BASES-1:0]  key,
  output logic                    search_load,
  input  logic                    match,
  output logic                    err_char
);

  localparam int KEY_W  = 2 * KEY_BASES;
  localparam int DATA_W = 2 * DATA_BASES;

  logic [1:0] code;
  logic       is_base;
  logic       is_skip;

  base_encoder u_base_encoder (
    .in_byte (bus.in_byte),
    .code    (code),
    .is_base (is_base),
    .is_skip (is_skip)
  );

  state_t            state_q, state_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              found_q, found_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              search_load_q, search_load_d;
  logic              result_valid_q, result_valid_d;
  logic              result_found_q, result_found_d;
  logic              err_char_q, err_char_d;
  logic              in_ready_q, in_ready_d;

  logic        accept;
  logic [31:0] key_sh, data_sh;

  assign accept = bus.in_valid && in_ready_q;

  // Base n lands MSB-first, so its bit offset counts down from the top.
  assign key_sh  = 32'(2 * (KEY_BASES - 1))  - {22'd0, cnt_q, 1'b0};
  assign data_sh = 32'(2 * (DATA_BASES - 1)) - {22'd0, cnt_q, 1'b0};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    found_d        = found_q;
    key_d          = key_q;
    data_d         = data_q;
    search_load_d  = 1'b0;
    result_valid_d = result_valid_q;
    result_found_d = result_found_q;
    err_char_d     = 1'b0;

    case (state_q)
      ST_LOAD_KEY, ST_LOAD_DATA: begin
        if (accept) begin
          if (is_base) begin
            if (state_q == ST_LOAD_KEY) begin
              key_d = (key_q & ~(KEY_W'(2'b11) << key_sh)) | (KEY_W'(code) << key_sh);
              if (cnt_q == 9'(KEY_BASES - 1)) begin
                state_d = ST_LOAD_DATA;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 9'd1;
              end
            end else begin
              data_d = (data_q & ~(DATA_W'(2'b11) << data_sh)) | (DATA_W'(code) << data_sh);
              if (cnt_q == 9'(DATA_BASES - 1)) begin
                state_d       = ST_START;
                cnt_d         = '0;
                search_load_d = 1'b1;
                found_d       = 1'b0;
              end else begin
                cnt_d = cnt_q + 9'd1;
              end
            end
          end else if (!is_skip) begin
            // Bad character restarts the frame; packed registers keep stale bits.
            err_char_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_LOAD_KEY;
          end
        end
      end
      ST_START: begin
        state_d = ST_SCAN;
        cnt_d   = '0;
      end
      ST_SCAN: begin
        found_d = found_q | match;
        if (cnt_q == 9'(SCAN_CYCLES - 1)) begin
          state_d        = ST_REPORT;
          cnt_d          = '0;
          result_valid_d = 1'b1;
          result_found_d = found_d;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      ST_REPORT: begin
        if (result_valid_q && bus.result_ready) begin
          result_valid_d = 1'b0;
          result_found_d = 1'b0;
          state_d        = ST_LOAD_KEY;
          cnt_d          = '0;
        end
      end
      default: begin
        state_d = ST_LOAD_KEY;
        cnt_d   = '0;
      end
    endcase

    in_ready_d = (state_d == ST_LOAD_KEY) || (state_d == ST_LOAD_DATA);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_LOAD_KEY;
      cnt_q          <= '0;
      found_q        <= 1'b0;
      key_q          <= '0;
      data_q         <= '0;
      search_load_q  <= 1'b0;
      result_valid_q <= 1'b0;
      result_found_q <= 1'b0;
      err_char_q     <= 1'b0;
      in_ready_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      found_q        <= found_d;
      key_q          <= key_d;
      data_q         <= data_d;
      search_load_q  <= search_load_d;
      result_valid_q <= result_valid_d;
      result_found_q <= result_found_d;
      err_char_q     <= err_char_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_found = result_found_q;
  assign data             = data_q;
  assign key              = key_q;
  assign search_load      = search_load_q;
  assign err_char         = err_char_q;

endmodule

// File: tb/tb_sequence_loader.sv
// Directed and randomized frames against a base-list reference model of the loader.
module tb_sequence_loader;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         match = 1'b0;
  logic         search_load;
  logic         err_char;
  logic [511:0] data_o;
  logic [63:0]  key_o;

  sequence_loader_if bus ();

  sequence_loader dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .data        (data_o),
    .key         (key_o),
    .search_load (search_load),
    .match       (match),
    .err_char    (err_char)
  );

  always #5 clock = ~clock;

  int    tests = 0;
  int    fails = 0;
  int    kb[32];
  int    db[256];
  string bases_s = "ACGT";

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] base_char(input int b, input bit lower);
    logic [7:0] c;
    c = bases_s[b];
    if (lower) c = c + 8'd32;
    return c;
  endfunction

  // Reference: the key/data are the base list read as one base-4 number.
  function automatic logic [63:0] model_key();
    logic [63:0] k = '0;
    for (int n = 0; n < 32; n++) k = k * 4 + 64'(kb[n]);
    return k;
  endfunction

  function automatic logic [511:0] model_data();
    logic [511:0] d = '0;
    for (int n = 0; n < 256; n++) d = d * 4 + 512'(db[n]);
    return d;
  endfunction

  task automatic send(input logic [7:0] b, output bit ok);
    int t = 0;
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    while (!bus.in_ready && t < 1000) begin
      @(negedge clock);
      t++;
    end
    ok = (t < 1000);
    if (ok) @(posedge clock);
  endtask

  task automatic send_bases(input int count, input bit lower, input int crlf_every);
    bit ok = 1'b1;
    for (int i = 0; i < count && ok; i++) begin
      if (crlf_every > 0 && i > 0 && (i % crlf_every) == 0) begin
        send(8'h0D, ok);
        if (ok) send(8'h0A, ok);
      end
      if (ok) send(base_char(i < 32 ? kb[i] : db[i - 32], lower), ok);
    end
    check("send_accepted", ok, 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_result_found"}, bus.result_found, 0);
    check({tag, "_search_load"}, search_load, 0);
    check({tag, "_err_char"}, err_char, 0);
    check({tag, "_key"}, key_o, 0);
    check({tag, "_data"}, data_o, 0);
  endtask

  task automatic do_reset(input string tag);
    bit seen = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.result_ready = 1'b0;
    match = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs(tag);
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      if (bus.result_valid || search_load) seen = 1'b1;
    end
    check({tag, "_no_result"}, seen, 0);
  endtask

  task automatic run_scan(input int match_k, input bit spur, input int delay, input int abort_n);
    logic [63:0]  ek;
    logic [511:0] ed;
    bit           ef;
    ek = model_key();
    ed = model_data();
    ef = (match_k >= 0 && match_k < 116);
    @(negedge clock);
    bus.in_valid = 1'b0;
    match = spur;
    check("start_search_load", search_load, 1);
    check("start_in_ready", bus.in_ready, 0);
    check("start_key", key_o, ek);
    check("start_data", data_o, ed);
    for (int n = 1; n <= 116; n++) begin
      @(negedge clock);
      match = (n - 1 == match_k);
      if (n == abort_n) begin
        do_reset("scan_abort");
        return;
      end
      if (n == 1) check("scan_search_load_low", search_load, 0);
      if (n == 60) check("scan_in_ready", bus.in_ready, 0);
      if (n == 116) check("scan_no_result_yet", bus.result_valid, 0);
    end
    @(negedge clock);
    match = spur;
    check("report_valid", bus.result_valid, 1);
    check("report_found", bus.result_found, ef);
    for (int i = 0; i < delay; i++) begin
      @(negedge clock);
      check("report_hold_valid", bus.result_valid, 1);
      check("report_hold_found", bus.result_found, ef);
      check("report_in_ready", bus.in_ready, 0);
    end
    bus.result_ready = 1'b1;
    match = 1'b0;
    @(negedge clock);
    bus.result_ready = 1'b0;
    check("after_report_valid", bus.result_valid, 0);
    check("after_report_in_ready", bus.in_ready, 1);
    check("after_report_key_held", key_o, ek);
    check("after_report_data_held", data_o, ed);
  endtask

  task automatic set_acgt_frame();
    for (int i = 0; i < 32; i++) kb[i] = i % 4;
    for (int i = 0; i < 256; i++) db[i] = 0;
  endtask

  task automatic set_random_frame();
    for (int i = 0; i < 32; i++) kb[i] = int'($urandom_range(3, 0));
    for (int i = 0; i < 256; i++) db[i] = int'($urandom_range(3, 0));
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int mk;
    bus.in_valid     = 1'b0;
    bus.in_byte      = 8'h00;
    bus.result_ready = 1'b0;

    // Power-on reset then idle.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle_outputs("reset");

    // Fixed ACGT key, all-A data, no match.
    set_acgt_frame();
    send_bases(288, 1'b0, 0);
    run_scan(-1, 1'b0, 0, 0);
    check("acgt_key_const", key_o, 64'h1B1B1B1B1B1B1B1B);
    check("acgt_data_const", data_o, 0);

    // Same frame, match at scan cycle 50, stray match in START/REPORT.
    send_bases(288, 1'b0, 0);
    run_scan(50, 1'b1, 3, 0);

    // Invalid character mid-key restarts the frame.
    for (int i = 0; i < 9; i++) send(8'h54, ok);
    send(8'h4E, ok);
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("err_pulse", err_char, 1);
    @(negedge clock);
    check("err_pulse_end", err_char, 0);
    send_bases(288, 1'b0, 0);
    run_scan(-1, 1'b0, 0, 0);
    check("err_key_const", key_o, 64'h1B1B1B1B1B1B1B1B);

    // Lowercase with CR/LF every 16 bases.
    send_bases(288, 1'b1, 16);
    run_scan(-1, 1'b0, 1, 0);

    // Random frame, result held 20 cycles.
    set_random_frame();
    send_bases(288, 1'b0, 0);
    run_scan(int'($urandom_range(115, 0)), 1'b0, 20, 0);

    // Reset after 100 data bases, then a clean frame.
    set_random_frame();
    send_bases(132, 1'b0, 0);
    do_reset("data_abort");
    set_random_frame();
    send_bases(288, 1'b0, 0);
    run_scan(0, 1'b0, 0, 0);

    // Reset mid-scan, then a frame matching only on the last scan cycle.
    set_random_frame();
    send_bases(288, 1'b1, 7);
    run_scan(10, 1'b0, 0, 40);
    set_random_frame();
    send_bases(288, 1'b0, 0);
    run_scan(115, 1'b1, 2, 0);

    // Randomized frames.
    for (int f = 0; f < 4; f++) begin
      set_random_frame();
      case ($urandom_range(3, 0))
        0: mk = -1;
        1: mk = 0;
        2: mk = 115;
        default: mk = int'($urandom_range(115, 0));
      endcase
      send_bases(288, 1'($urandom_range(1, 0)), ($urandom_range(1, 0) != 0) ? 16 : 0);
      run_scan(mk, 1'($urandom_range(1, 0)), int'($urandom_range(4, 0)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
